// File: rtl/bus_pkg.sv
// bus_pkg: shared widths, trap word, arbiter state and owner encodings for the memory bus.
package bus_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int STRB_W = 2;
    localparam logic [DATA_W-1:0] TRAP_INSN = 16'hFFFF;
    localparam logic [1:0] M0 = 2'b01;
    localparam logic [1:0] M1 = 2'b10;
    typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: valid/ready memory request channel; master issues, slave completes.
interface mem_bus_arbiter_if;
    import bus_pkg::*;
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              ready;
    logic [DATA_W-1:0] rdata;
    modport master (output valid, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/bus_watchdog.sv
// bus_watchdog: counts stalled cycles and flags expiry once TIMEOUT-1 stalls have accumulated.
module bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en) cnt <= cnt + 16'd1;
    end
    always_comb expire = cnt == 16'(TIMEOUT - 1);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: grants the shared memory port to m0 or m1 one transaction at a time,
// with fixed or round-robin priority and a watchdog that completes hung requests with TRAP_WORD.
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter bit                ROUND_ROBIN = 1'b1,
    parameter int                TIMEOUT     = 255,
    parameter logic [DATA_W-1:0] TRAP_WORD   = TRAP_INSN
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave  m0,
    mem_bus_arbiter_if.slave  m1,
    mem_bus_arbiter_if.master s,
    output logic [1:0]       grant,
    output logic             timeout_err
);
    arb_state_t state;
    logic pref_m1, busy, ov, expire, trap, done;

    bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk(clk),
        .rst(rst),
        .clr(!busy),
        .en(busy && !s.ready),
        .expire(expire)
    );

    // A real s_ready in the expiry cycle takes precedence over the trap completion.
    always_comb begin
        busy = state == BUSY;
        ov = grant == M1 ? m1.valid : grant == M0 ? m0.valid : 1'b0;
        trap = busy && ov && expire && !s.ready;
        done = !rst && busy && ov && (s.ready || expire);
        s.valid = !rst && busy && ov && !trap;
        s.addr = grant == M1 ? m1.addr : grant == M0 ? m0.addr : '0;
        s.wdata = grant == M1 ? m1.wdata : grant == M0 ? m0.wdata : '0;
        s.wstrb = grant == M1 ? m1.wstrb : grant == M0 ? m0.wstrb : '0;
        m0.ready = done && grant == M0;
        m1.ready = done && grant == M1;
        m0.rdata = m0.ready ? (s.ready ? s.rdata : TRAP_WORD) : '0;
        m1.rdata = m1.ready ? (s.ready ? s.rdata : TRAP_WORD) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            pref_m1 <= 1'b0;
            timeout_err <= 1'b0;
        end else if (state == IDLE) begin
            if (m0.valid || m1.valid) begin
                state <= BUSY;
                grant <= (m0.valid && m1.valid) ? ((ROUND_ROBIN && pref_m1) ? M1 : M0) : m0.valid ? M0 : M1;
            end
        end else if (done || !ov) begin
            state <= IDLE;
            grant <= '0;
            if (done) pref_m1 <= grant == M0;
            if (trap) timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: round-robin and fixed-priority arbiters sharing master stimulus,
// each with its own slave; sel chooses which one the masters follow and the checks observe.
module tb_mem_bus_arbiter;
    import bus_pkg::*;
    localparam int TO = 8;

    typedef struct {
        bit          m;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  strb;
        logic [15:0] rdata;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic m0v = 0, m1v = 0;
    logic [15:0] m0a = 0, m0d = 0, m1a = 0, m1d = 0;
    logic [1:0] m0s = 0, m1s = 0;
    int dly = 1, sca = 0, scf = 0;
    bit sel = 0;
    int checks = 0, failures = 0;

    mem_bus_arbiter_if ra0(), ra1(), ras(), fa0(), fa1(), fas();
    logic [1:0] gr, gf;
    logic er_, ef_;

    assign ra0.valid = m0v; assign ra0.addr = m0a; assign ra0.wdata = m0d; assign ra0.wstrb = m0s;
    assign fa0.valid = m0v; assign fa0.addr = m0a; assign fa0.wdata = m0d; assign fa0.wstrb = m0s;
    assign ra1.valid = m1v; assign ra1.addr = m1a; assign ra1.wdata = m1d; assign ra1.wstrb = m1s;
    assign fa1.valid = m1v; assign fa1.addr = m1a; assign fa1.wdata = m1d; assign fa1.wstrb = m1s;

    mem_bus_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(TO)) dut_rr (
        .clk(clk), .rst(rst), .m0(ra0), .m1(ra1), .s(ras), .grant(gr), .timeout_err(er_));
    mem_bus_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(TO)) dut_fx (
        .clk(clk), .rst(rst), .m0(fa0), .m1(fa1), .s(fas), .grant(gf), .timeout_err(ef_));

    // Slave answers dly cycles after the first granted cycle; rdata is a fixed scramble of addr.
    always @(posedge clk) begin
        sca <= (gr == 2'b00) ? 0 : sca + 1;
        scf <= (gf == 2'b00) ? 0 : scf + 1;
    end
    assign ras.ready = gr != 2'b00 && sca == dly;
    assign fas.ready = gf != 2'b00 && scf == dly;
    assign ras.rdata = ras.addr ^ 16'hACDB;
    assign fas.rdata = fas.addr ^ 16'hACDB;

    logic [1:0] g, vstrb;
    logic e, sv, r0, r1;
    logic [15:0] vaddr, vwdata, d0, d1;
    assign g = sel ? gf : gr;
    assign e = sel ? ef_ : er_;
    assign sv = sel ? fas.valid : ras.valid;
    assign vaddr = sel ? fas.addr : ras.addr;
    assign vwdata = sel ? fas.wdata : ras.wdata;
    assign vstrb = sel ? fas.wstrb : ras.wstrb;
    assign r0 = sel ? fa0.ready : ra0.ready;
    assign r1 = sel ? fa1.ready : ra1.ready;
    assign d0 = sel ? fa0.rdata : ra0.rdata;
    assign d1 = sel ? fa1.rdata : ra1.rdata;

    vec_t tv[4];
    logic [1:0] order[6];
    int rise[6];
    int dlys[7] = '{1, 1, 2, 3, 7, 8, 12};
    bit last_m1, eterr, prdy, pv0, pv1, q0, q1;
    logic [1:0] pg, eg, erd;
    int k, exp_n, n, c0, c1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; m0v = 0; m1v = 0;
        step();
        step();
        rst = 0;
    endtask

    function automatic logic [1:0] pick(input logic v0, input logic v1);
        if (v0 && v1) return (sel == 0 && !last_m1) ? 2'b10 : 2'b01;
        return v0 ? 2'b01 : v1 ? 2'b10 : 2'b00;
    endfunction

    task automatic single(input vec_t v);
        logic [1:0] oh;
        oh = v.m ? 2'b10 : 2'b01;
        if (v.m) begin m1v = 1; m1a = v.addr; m1d = v.wdata; m1s = v.strb; end
        else begin m0v = 1; m0a = v.addr; m0d = v.wdata; m0s = v.strb; end
        @(negedge clk);
        chk("tbl_idle_grant", g, 2'b00);
        chk("tbl_idle_svalid", sv, 1'b0);
        step();
        @(negedge clk);
        chk("tbl_grant", g, oh);
        chk("tbl_svalid", sv, 1'b1);
        chk("tbl_saddr", vaddr, v.addr);
        chk("tbl_swdata", vwdata, v.wdata);
        chk("tbl_swstrb", vstrb, v.strb);
        chk("tbl_early_ready", {r1, r0}, 2'b00);
        step();
        @(negedge clk);
        chk("tbl_ready", {r1, r0}, oh);
        chk("tbl_rdata", v.m ? d1 : d0, v.rdata);
        chk("tbl_other_rdata", v.m ? d0 : d1, 16'h0000);
        step();
        m0v = 0; m1v = 0;
        @(negedge clk);
        chk("tbl_after_grant", g, 2'b00);
        chk("tbl_after_ready", {r1, r0}, 2'b00);
        step();
    endtask

    initial begin
        tv[0] = '{1'b0, 16'h1234, 16'h0000, 2'b00, 16'hBEEF};
        tv[1] = '{1'b1, 16'h8000, 16'h00AA, 2'b01, 16'h2CDB};
        tv[2] = '{1'b0, 16'h00FF, 16'h5555, 2'b11, 16'hAC24};
        tv[3] = '{1'b1, 16'h4321, 16'h0000, 2'b00, 16'hEFFA};

        do_reset();
        @(negedge clk);
        chk("rst_grant", g, 2'b00);
        chk("rst_svalid", sv, 1'b0);
        chk("rst_saddr", vaddr, 16'h0000);
        chk("rst_ready", {r1, r0}, 2'b00);
        chk("rst_rdata", {d1, d0}, 32'h0);
        chk("rst_err", e, 1'b0);
        step();

        for (int i = 0; i < 4; i++) single(tv[i]);

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            do_reset();
            dly = 1; m0v = 1; m1v = 1; m0a = 16'h2000; m1a = 16'h3000;
            c0 = 0; c1 = 0; n = 0; pg = 0;
            for (int cyc = 0; cyc < 60 && (c0 < 3 || c1 < 3); cyc++) begin
                @(negedge clk);
                if (g != 2'b00 && pg == 2'b00 && n < 6) begin order[n] = g; rise[n] = cyc; n++; end
                pg = g; q0 = r0; q1 = r1;
                step();
                if (q0) begin c0++; if (c0 == 3) m0v = 0; else m0a++; end
                if (q1) begin c1++; if (c1 == 3) m1v = 0; else m1a++; end
            end
            chk("cont_count", n, 6);
            for (int i = 0; i < n; i++) begin
                chk("cont_order", order[i], sel ? (i < 3 ? 2'b01 : 2'b10) : (i % 2 ? 2'b10 : 2'b01));
                if (i > 0) chk("cont_spacing", rise[i] - rise[i-1], 3);
            end
            m0v = 0; m1v = 0;
        end

        sel = 0;
        do_reset();
        dly = 1000; m0v = 1; m0a = 16'h0100; m0s = 2'b00;
        step();
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            chk("wd_ready", r0, i == TO);
            chk("wd_svalid", sv, i != TO);
            if (i == TO) chk("wd_rdata", d0, 16'hFFFF);
            step();
        end
        m0v = 0;
        @(negedge clk);
        chk("wd_err_set", e, 1'b1);
        chk("wd_idle", g, 2'b00);
        step();
        dly = 1;
        single(tv[0]);
        @(negedge clk);
        chk("wd_err_sticky", e, 1'b1);
        step();

        m0v = 1; m0a = 16'h0200;
        step();
        @(negedge clk);
        chk("rst_busy_svalid", sv, 1'b1);
        step();
        rst = 1;
        @(negedge clk);
        chk("rst_busy_noready", {r1, r0}, 2'b00);
        step();
        rst = 0; m0v = 0;
        @(negedge clk);
        chk("rst_busy_grant", g, 2'b00);
        chk("rst_busy_sv", sv, 1'b0);
        chk("rst_busy_rdy", {r1, r0}, 2'b00);
        chk("rst_busy_err", e, 1'b0);
        step();

        do_reset();
        dly = TO - 1; m1v = 1; m1a = 16'h0F0F; m1s = 2'b00;
        step();
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            chk("coin_ready", r1, i == TO);
            chk("coin_svalid", sv, 1'b1);
            if (i == TO) chk("coin_rdata", d1, 16'hA3D4);
            step();
        end
        m1v = 0;
        @(negedge clk);
        chk("coin_err", e, 1'b0);
        step();

        do_reset();
        dly = 1;
        single(tv[0]);
        dly = 5; m1v = 1; m1a = 16'h0300;
        step();
        @(negedge clk);
        chk("abort_grant", g, 2'b10);
        step();
        m1v = 0;
        @(negedge clk);
        chk("abort_sv", sv, 1'b0);
        chk("abort_rdy", {r1, r0}, 2'b00);
        step();
        @(negedge clk);
        chk("abort_idle", g, 2'b00);
        chk("abort_rdy2", {r1, r0}, 2'b00);
        step();
        m0v = 1; m1v = 1;
        step();
        @(negedge clk);
        chk("abort_rr_kept", g, 2'b10);
        step();
        m0v = 0; m1v = 0;

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            do_reset();
            last_m1 = 1; eterr = 0; pg = 0; prdy = 0; pv0 = 0; pv1 = 0; k = 0; exp_n = 0; dly = 1;
            for (int cyc = 0; cyc < 600; cyc++) begin
                @(negedge clk);
                eg = pg == 2'b00 ? pick(pv0, pv1) : prdy ? 2'b00 : pg;
                chk("rnd_grant", g, eg);
                if (eg != 2'b00 && pg == 2'b00) begin k = 1; exp_n = dly + 1 < TO ? dly + 1 : TO; end
                else k++;
                erd = (eg != 2'b00 && k == exp_n) ? eg : 2'b00;
                chk("rnd_ready", {r1, r0}, erd);
                chk("rnd_svalid", sv, eg != 2'b00 && !(erd != 2'b00 && dly >= TO));
                chk("rnd_err", e, eterr);
                if (eg != 2'b00) chk("rnd_saddr", vaddr, eg[1] ? m1a : m0a);
                if (erd != 2'b00) begin
                    chk("rnd_rdata", erd[1] ? d1 : d0, dly >= TO ? 16'hFFFF : (erd[1] ? m1a : m0a) ^ 16'hACDB);
                    last_m1 = erd[1];
                    if (dly >= TO) eterr = 1;
                end
                pg = eg; prdy = erd != 2'b00; pv0 = m0v; pv1 = m1v;
                step();
                if (erd[0]) m0v = 0;
                if (erd[1]) m1v = 0;
                if (!m0v && $urandom_range(2) == 0) begin
                    m0v = 1; m0a = 16'($urandom); m0d = 16'($urandom); m0s = 2'($urandom);
                end
                if (!m1v && $urandom_range(2) == 0) begin
                    m1v = 1; m1a = 16'($urandom); m1d = 16'($urandom); m1s = 2'($urandom);
                end
                if (eg == 2'b00) dly = dlys[$urandom_range(6)];
            end
            m0v = 0; m1v = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
